gp_chain_pipe: RTL and testbench

Parametrised, pipelined generate/propagate carry-chain evaluator. It computes the full prefix of an N-stage chain c[i+1] = g[i] | (p[i] & c[i]) and returns every intermediate carry, not only the last one. It inserts a pipeline register every STAGE chain links and moves transactions with a valid/ready handshake and full backpressure. It sits between operand-formatting logic and any consumer of carry/prefix vectors, such as adders, comparators and priority chains.

---
 rtl/gp_chain_pipe.sv | 141 ++++++++++++++
 tb/tb_gp_chain_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_chain_pipe.sv
// ---------------------------------------------------------------------------
// gp_chain_pipe
//   Pipelined generate/propagate carry-chain evaluator. Computes every carry
//   of c[i+1] = g[i] | (p[i] & c[i]) for i = 0..N-1, cutting the chain with a
//   register after every STAGE links. The pipeline has D = ceil(N/STAGE)
//   stages and moves transactions under a global enable (valid/ready with
//   full backpressure).
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   transaction present on g/p/c_in
//   in_ready   block accepts a transaction this cycle (= out_ready | ~out_valid)
//   c_in       chain input c[0]
//   g, p       [N-1:0] generate / propagate bits, bit i belongs to link i
//   out_valid  result present on c_out/c_last
//   out_ready  consumer accepts the result this cycle
//   c_out      [N-1:0] c_out[i] = c[i+1]
//   c_last     c[N] (= c_out[N-1])
// ---------------------------------------------------------------------------

// One link of the chain: a single AND-OR level.
module gp_link (
  input  logic g_i,
  input  logic p_i,
  input  logic c_i,
  output logic c_o
);
  assign c_o = g_i | (p_i & c_i);
endmodule

module gp_chain_pipe #(
  parameter int N     = 8,
  parameter int STAGE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         c_in,
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c_out,
  output logic         c_last
);

  localparam int D = (N + STAGE - 1) / STAGE;

  // Global enable: every stage moves together, so a stalled output freezes
  // the whole pipe and bubbles travel through like data.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Valid shift register; bit 0 is the incoming valid, bits [D:1] are flops.
  logic [D:0] vld_pipe;
  logic [D:1] vld_q;

  assign vld_pipe = {vld_q, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[D-1:0];
  end

  assign out_valid = vld_pipe[D];

  // Per-link evaluation cells; each stage wires up its own slice.
  logic [N-1:0] lg, lp, lc, lco;

  gp_link u_link [N-1:0] (
    .g_i (lg),
    .p_i (lp),
    .c_i (lc),
    .c_o (lco)
  );

  for (genvar s = 0; s < D; s++) begin : g_stg
    localparam int LO = s * STAGE;
    localparam int HI = (LO + STAGE < N) ? (LO + STAGE) : N;

    // Carries c[1..HI] known after this stage; the top one is the running
    // carry handed to the next stage, so no separate carry flop is kept.
    logic [HI-1:0]   cv_q;
    // g/p bits still outstanding on entry: [HI-1:LO] are evaluated here,
    // [N-1:HI] are forwarded. Consumed bits are never registered again.
    logic [N-1:LO]   gs, ps;
    logic            cs;

    if (s == 0) begin : g_src0
      assign gs = g;
      assign ps = p;
      assign cs = c_in;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cv_q <= '0;
        else if (adv) cv_q <= lco[HI-1:0];
      end
    end else begin : g_srcn
      assign gs = g_stg[s-1].g_keep.g_q;
      assign ps = g_stg[s-1].g_keep.p_q;
      assign cs = g_stg[s-1].cv_q[LO-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cv_q <= '0;
        else if (adv) cv_q <= {lco[HI-1:LO], g_stg[s-1].cv_q};
      end
    end

    // Feed this stage's links: first link takes the stage carry, the rest
    // ripple combinationally inside the stage.
    assign lg[HI-1:LO] = gs[HI-1:LO];
    assign lp[HI-1:LO] = ps[HI-1:LO];
    assign lc[LO]      = cs;
    for (genvar k = LO + 1; k < HI; k++) begin : g_rip
      assign lc[k] = lco[k-1];
    end

    // Forward the not-yet-consumed g/p bits (absent in the final stage).
    if (HI < N) begin : g_keep
      logic [N-1:HI] g_q, p_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_q <= '0;
          p_q <= '0;
        end else if (adv) begin
          g_q <= gs[N-1:HI];
          p_q <= ps[N-1:HI];
        end
      end
    end
  end

  // Outputs come straight from last-stage flops.
  assign c_out  = g_stg[D-1].cv_q;
  assign c_last = c_out[N-1];

endmodule

// File: tb/tb_gp_chain_pipe.sv
// ---------------------------------------------------------------------------
// tb_gp_chain_pipe
//   Self-checking bench: a N=8/STAGE=2 instance driven from a vector table and
//   hand-written sequences (backpressure, bubbles, mid-stream reset), checked
//   against a valid-pipe model plus an expected-result queue; four more
//   instances with other (N,STAGE) pairs run random traffic and check values
//   and latency against a reference chain function.
// ---------------------------------------------------------------------------
module tb_gp_chain_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   sweep_go   = 1'b0;
  int   sweep_done = 0;

  function automatic logic [15:0] ref_chain(input int n, input logic ci,
                                            input logic [15:0] gg,
                                            input logic [15:0] pp);
    logic c;
    logic [15:0] r;
    c = ci;
    r = '0;
    for (int i = 0; i < n; i++) begin
      c    = gg[i] | (pp[i] & c);
      r[i] = c;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- main instance: N=8, STAGE=2, D=4 ----------------
  logic       m_iv, m_ir, m_ci, m_ov, m_or, m_cl;
  logic [7:0] m_g, m_p, m_co;

  gp_chain_pipe #(.N(8), .STAGE(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .c_in      (m_ci),
    .g         (m_g),
    .p         (m_p),
    .out_valid (m_ov),
    .out_ready (m_or),
    .c_out     (m_co),
    .c_last    (m_cl)
  );

  typedef struct { logic [7:0] co; logic cl; } exp_t;
  typedef struct { logic ci; logic [7:0] g; logic [7:0] p; logic [7:0] co; logic cl; } tv_t;

  exp_t       sb[$];
  logic [3:0] mv;   // model of the valid slots, mv[3] = expected out_valid

  // One cycle: drive at negedge, check just after, then account for the
  // transfers that the coming rising edge will perform.
  task automatic step(input logic iv, input logic ci, input logic [7:0] gg,
                      input logic [7:0] pp, input logic [7:0] ec, input logic el,
                      input logic orr, output logic acc);
    logic eov, eir;
    @(negedge clk);
    m_iv = iv; m_ci = ci; m_g = gg; m_p = pp; m_or = orr;
    #1;
    eov = mv[3];
    eir = orr | ~eov;
    chk("out_valid", 16'(m_ov), 16'(eov));
    chk("in_ready",  16'(m_ir), 16'(eir));
    if (eov) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got output with no expected entry");
      end else begin
        chk("c_out",  16'(m_co), 16'(sb[0].co));
        chk("c_last", 16'(m_cl), 16'(sb[0].cl));
        if (orr) void'(sb.pop_front());
      end
    end
    acc = iv & eir;
    if (acc) sb.push_back('{ec, el});
    if (eir) mv = {mv[2:0], iv};
  endtask

  tv_t tv[8];

  initial begin
    logic        acc, rc;
    logic [7:0]  rg, rp, pat;
    logic [15:0] e;
    int          sent;
    logic [5:0]  bub;

    tv[0] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 1'b1};  // propagate ripple
    tv[1] = '{1'b0, 8'h01, 8'h00, 8'h01, 1'b0};  // isolated generate
    tv[2] = '{1'b0, 8'h08, 8'hF0, 8'hF8, 1'b1};  // generate then propagate
    tv[3] = '{1'b1, 8'h00, 8'h0F, 8'h0F, 1'b0};
    tv[4] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
    tv[5] = '{1'b1, 8'h80, 8'h00, 8'h80, 1'b1};
    tv[6] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b1};
    tv[7] = '{1'b1, 8'h00, 8'h55, 8'h01, 1'b0};

    rst_n = 1'b0;
    m_iv = 1'b0; m_ci = 1'b0; m_g = '0; m_p = '0; m_or = 1'b0;
    mv = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 16'(m_ov), 16'(0));
    chk("rst_c_out",     16'(m_co), 16'(0));
    chk("rst_c_last",    16'(m_cl), 16'(0));
    chk("rst_in_ready",  16'(m_ir), 16'(1));

    // table vectors, back to back
    for (int i = 0; i < 8; i++)
      step(1'b1, tv[i].ci, tv[i].g, tv[i].p, tv[i].co, tv[i].cl, 1'b1, acc);
    repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // backpressure: 10 transactions, out_ready = 1,0,0,1,0,1,1,0 repeating
    pat  = 8'b0110_1001;
    sent = 0;
    rc = 1'($urandom); rg = 8'($urandom); rp = 8'($urandom);
    for (int c = 0; c < 80 && (sent < 10 || sb.size() > 0); c++) begin
      e = ref_chain(8, rc, 16'(rg), 16'(rp));
      step(sent < 10, rc, rg, rp, e[7:0], e[7], pat[c % 8], acc);
      if (acc) begin
        sent++;
        rc = 1'($urandom); rg = 8'($urandom); rp = 8'($urandom);
      end
    end
    chk("bp_sent", 16'(sent), 16'(10));
    chk("bp_left", 16'(sb.size()), 16'(0));

    // bubbles: in_valid 1,0,1,0,0,1 with out_ready high
    bub = 6'b100101;
    for (int i = 0; i < 6; i++) begin
      rc = 1'($urandom); rg = 8'($urandom); rp = 8'($urandom);
      e = ref_chain(8, rc, 16'(rg), 16'(rp));
      step(bub[i], rc, rg, rp, e[7:0], e[7], 1'b1, acc);
    end
    repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    chk("bub_left", 16'(sb.size()), 16'(0));

    // mid-stream reset with a full, stalled pipe
    repeat (4) step(1'b1, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(m_ov), 16'(0));
    chk("mid_rst_c_out",     16'(m_co), 16'(0));
    chk("mid_rst_c_last",    16'(m_cl), 16'(0));
    chk("mid_rst_in_ready",  16'(m_ir), 16'(1));
    sb.delete();
    mv = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, acc);

    // parameter sweep instances
    sweep_go = 1'b1;
    for (int c = 0; c < 5000 && sweep_done < 4; c++) @(negedge clk);
    chk("sweep_done", 16'(sweep_done), 16'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar i = 0; i < 4; i++) begin : g_sw
    localparam int NN = (i == 0) ? 1 : (i == 1) ? 5 : (i == 2) ? 8 : 13;
    localparam int SS = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 4;
    localparam int DD = (NN + SS - 1) / SS;

    logic          iv, ir, ci, ov, orr, cl;
    logic [NN-1:0] gg, pp, co;

    gp_chain_pipe #(.N(NN), .STAGE(SS)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .c_in      (ci),
      .g         (gg),
      .p         (pp),
      .out_valid (ov),
      .out_ready (orr),
      .c_out     (co),
      .c_last    (cl)
    );

    typedef struct { logic [15:0] co; int idx; } sx_t;
    sx_t q[$];

    initial begin
      int          sent, idx;
      logic [15:0] e;
      sx_t         h;
      iv = 1'b0; ci = 1'b0; gg = '0; pp = '0; orr = 1'b1;
      wait (sweep_go);
      sent = 0;
      idx  = 0;
      while ((sent < 200 || q.size() > 0) && idx < 3000) begin
        @(negedge clk);
        iv = (sent < 200) && ($urandom_range(0, 3) != 0);
        ci = 1'($urandom);
        gg = NN'($urandom);
        pp = NN'($urandom);
        #1;
        idx++;
        chk($sformatf("sw%0d_in_ready", i), 16'(ir), 16'(1));
        if (ov) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL sw%0d_extra: got output with no expected entry", i);
          end else begin
            h = q.pop_front();
            chk($sformatf("sw%0d_c_out", i),   16'(co), h.co);
            chk($sformatf("sw%0d_c_last", i),  16'(cl), 16'(h.co[NN-1]));
            chk($sformatf("sw%0d_latency", i), 16'(idx - h.idx), 16'(DD));
          end
        end
        if (iv && ir) begin
          e = ref_chain(NN, ci, 16'(gg), 16'(pp));
          q.push_back('{e, idx});
          sent++;
        end
      end
      chk($sformatf("sw%0d_sent", i), 16'(sent), 16'(200));
      chk($sformatf("sw%0d_left", i), 16'(q.size()), 16'(0));
      iv = 1'b0;
      sweep_done++;
    end
  end

endmodule
